// File: rtl/psum_drain.sv
// psum_drain: de-skews the systolic array's bottom-row partial sums into whole
// result rows and buffers them in a row FIFO.
// The FIFO presents rows on a valid/ready stream and reports free space.
// Optional feature macro: PSUM_ACCUM_EN adds a per-row accumulator bank for k-tiling.
module psum_drain #(
  parameter int ARRAY_DIM              = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH             = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ARRAY_DIM*ACCUMULATOR_DATA_WIDTH-1:0] psum_in,
  input  logic [ARRAY_DIM-1:0]                    psum_valid,
  input  logic                                    accum_last,
  output logic [ARRAY_DIM*ACCUMULATOR_DATA_WIDTH-1:0] out_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_free,
  output logic                                    tile_done,
  output logic                                    overflow_err,
  output logic                                    skew_err,
  input  logic                                    err_clear
);

  localparam int W   = ACCUMULATOR_DATA_WIDTH;
  localparam int RW  = ARRAY_DIM * W;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RCW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // ---- stage p0: per-column de-skew delay lines ----
  logic [ARRAY_DIM-1:0] vld_p0;
  logic [RW-1:0]        data_p0;

  for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
    localparam int D = ARRAY_DIM - 1 - j;
    if (D == 0) begin : g_nodly
      assign vld_p0[j]          = psum_valid[j];
      assign data_p0[j*W +: W]  = psum_in[j*W +: W];
    end else begin : g_dly
      logic [D-1:0]          vsr;
      logic signed [W-1:0]   dsr [D];
      // Valid chain: cleared on reset so no stale element survives into a row.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vsr <= '0;
        end else begin
          vsr[0] <= psum_valid[j];
          for (int k = 1; k < D; k++) vsr[k] <= vsr[k-1];
        end
      end
      // Data chain: qualified by the valid chain, so no reset needed.
      always_ff @(posedge clk) begin
        dsr[0] <= psum_in[j*W +: W];
        for (int k = 1; k < D; k++) dsr[k] <= dsr[k-1];
      end
      assign vld_p0[j]         = vsr[D-1];
      assign data_p0[j*W +: W] = dsr[D-1];
    end
  end

  logic row_ok_p0, skew_evt_p0;
  assign row_ok_p0   = &vld_p0;
  assign skew_evt_p0 = (|vld_p0) & ~row_ok_p0;

  // ---- stage p1: alignment register ----
  logic          vld_p1;
  logic          last_in_p1;
  logic [RW-1:0] data_p1;

  // Aligned-row valid and the tile-final flag that travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      last_in_p1 <= 1'b0;
    end else begin
      vld_p1     <= row_ok_p0;
      last_in_p1 <= accum_last;
    end
  end

  // Aligned-row data; meaningful only while vld_p1 is high.
  always_ff @(posedge clk) begin
    data_p1 <= data_p0;
  end

  // ---- row counter FSM ----
  state_t         state, state_n;
  logic [RCW-1:0] row_cnt, row_cnt_n, row_idx;
  logic           row_end;

  // State and row counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_n;
      row_cnt <= row_cnt_n;
    end
  end

  // Next state: a tile starts on the first aligned row and ends on row ARRAY_DIM-1.
  always_comb begin
    state_n   = state;
    row_cnt_n = row_cnt;
    row_idx   = (state == S_IDLE) ? '0 : row_cnt;
    row_end   = 1'b0;
    if (vld_p1) begin
      if (row_idx == RCW'(ARRAY_DIM - 1)) begin
        row_end   = 1'b1;
        state_n   = S_IDLE;
        row_cnt_n = '0;
      end else begin
        state_n   = S_DRAIN;
        row_cnt_n = row_idx + 1'b1;
      end
    end
  end

  // ---- push-side row selection ----
  logic          push_req;
  logic [RW-1:0] push_data;

`ifdef PSUM_ACCUM_EN
  function automatic logic signed [W-1:0] wrap_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    return a + b;
  endfunction

  logic signed [W-1:0] bank [ARRAY_DIM][ARRAY_DIM];
  logic                tile_final_q, eff_final;
  logic [RW-1:0]       acc_sum;

  assign eff_final = (state == S_IDLE) ? last_in_p1 : tile_final_q;

  // Row sum of the bank entry and the incoming aligned row, wrapping at W bits.
  always_comb begin
    acc_sum = '0;
    for (int j = 0; j < ARRAY_DIM; j++)
      acc_sum[j*W +: W] = wrap_add(bank[row_idx][j], $signed(data_p1[j*W +: W]));
  end

  // Latch whether the current tile is the final k-tile, sampled on its first row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         tile_final_q <= 1'b0;
    else if (vld_p1 && state == S_IDLE) tile_final_q <= last_in_p1;
  end

  // Accumulator bank: add on intermediate tiles, clear once the final sum leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ARRAY_DIM; r++)
        for (int j = 0; j < ARRAY_DIM; j++) bank[r][j] <= '0;
    end else if (vld_p1) begin
      for (int j = 0; j < ARRAY_DIM; j++)
        bank[row_idx][j] <= eff_final ? '0 : $signed(acc_sum[j*W +: W]);
    end
  end

  assign push_req  = vld_p1 & eff_final;
  assign push_data = acc_sum;
`else
  logic unused_accum_last;
  assign unused_accum_last = accum_last ^ last_in_p1;
  assign push_req  = vld_p1;
  assign push_data = data_p1;
`endif

  // ---- stage p2: row FIFO ----
  logic [RW-1:0]         mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, pop, push_ok, ovf_evt;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push_ok = push_req & (~full | pop);
  assign ovf_evt = push_req & full & ~pop;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop)     rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; each entry carries its row and the tile-last flag.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= push_data;
      mem_last[wr_ptr] <= (row_idx == RCW'(ARRAY_DIM - 1));
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid & mem_last[rd_ptr];
  assign fifo_free = CW'(FIFO_DEPTH) - count;

  // Tile-done pulse and sticky errors; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_done    <= 1'b0;
      overflow_err <= 1'b0;
      skew_err     <= 1'b0;
    end else begin
      tile_done    <= row_end;
      overflow_err <= ovf_evt     | (overflow_err & ~err_clear);
      skew_err     <= skew_evt_p0 | (skew_err & ~err_clear);
    end
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Sits below the bottom row of the systolic PE array; it is the consumer end of the partial-sum column outputs.
- Each column's results leave the array skewed, with column j lagging column 0 by j cycles. This block de-skews the columns into whole result rows and buffers them in a FIFO.
- Rows are presented downstream on a valid/ready stream, and the block reports buffer headroom so the array controller only launches a tile when ARRAY_DIM rows of space are free.

Parameters:
- ARRAY_DIM, 4, PE array width and height; rows per tile = columns = ARRAY_DIM.
- ACCUMULATOR_DATA_WIDTH, 16, width of each signed partial sum.
- FIFO_DEPTH, 8, output row FIFO entries; must be >= ARRAY_DIM.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- psum_in  in  ARRAY_DIM*ACCUMULATOR_DATA_WIDTH  bottom-row partial sums; column j at bits [j*W +: W].
- psum_valid  in  ARRAY_DIM  per-column valid; bit j qualifies column j this cycle.
- accum_last  in  1  marks a final k-tile; sampled with the first aligned row of a tile. Used only under PSUM_ACCUM_EN.
- out_data  out  ARRAY_DIM*ACCUMULATOR_DATA_WIDTH  aligned result row, same packing as psum_in.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_last  out  1  high with the final row (row ARRAY_DIM-1) of a tile.
- fifo_free  out  $clog2(FIFO_DEPTH+1)  free FIFO entries.
- tile_done  out  1  one-cycle pulse after a tile's last row is pushed.
- overflow_err  out  1  sticky; a row was dropped because the FIFO was full.
- skew_err  out  1  sticky; de-skewed column valids disagreed.
- err_clear  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset values: all outputs 0 except fifo_free = FIFO_DEPTH. FIFO, delay lines, counters and FSM are cleared.
- Reset mid-tile discards all in-flight data; no partial row is ever emitted afterwards.
- De-skew:
  - Column j (data and valid) passes through ARRAY_DIM-1-j register stages, so column ARRAY_DIM-1 has no delay.
  - Aligned valid is the AND of all delayed valids.
  - If the delayed valids are neither all 0 nor all 1, skew_err is set and that row is discarded.
- Alignment register: the aligned row is registered once before the FIFO push.
  - Latency: last-column element at cycle t, FIFO empty and out_ready high -> out_valid and out_data at cycle t+2.
- FSM:
  - IDLE: first aligned valid -> DRAIN, row counter = 0.
  - DRAIN: each aligned row pushes and increments the counter. After row ARRAY_DIM-1, pulse tile_done and return to IDLE.
  - Gaps between aligned rows are allowed; the state is held.
- out_last is stored per FIFO entry: set on the entry for counter == ARRAY_DIM-1.
- FIFO: first-word-fall-through on the registered head; out_data is stable while out_valid && !out_ready.
- Full-FIFO push:
  - Push when full with no pop in the same cycle -> row dropped, overflow_err set, row counter still advances.
  - Push and pop together when full -> both succeed; count unchanged.
- fifo_free reflects the registered count and updates the cycle after a push or pop.
- err_clear together with a new error event in the same cycle -> the error stays set.
- Arithmetic: no arithmetic occurs without the optional feature; data passes bit-exact.

Optional Feature:
- Macro: PSUM_ACCUM_EN.
- Defined: an internal ARRAY_DIM x ARRAY_DIM accumulator bank, indexed by row counter, enables k-tiling.
  - accum_last == 0 on a tile: each aligned row adds into bank[row] (two's-complement wrap at ACCUMULATOR_DATA_WIDTH). Nothing is pushed; tile_done still pulses.
  - accum_last == 1: push bank[row] + row, then clear bank[row] to 0.
  - The bank resets to 0.
- Undefined: no bank. accum_last is ignored and every tile passes straight through.

Test Plan:
- ARRAY_DIM=4; feed a 4x4 tile with skewed valids, row r col j = 16r+j, out_ready=1 -> four rows {16r+0..16r+3} in order, out_last only on row 3, tile_done one pulse, first out_valid 2 cycles after col 3 row 0.
- Hold out_ready=0 and feed two tiles (FIFO_DEPTH=8) -> fifo_free goes 8 to 0, no overflow; release ready -> 8 rows in order, fifo_free returns to 8.
- Feed a third tile while full with out_ready=0 -> overflow_err=1, 4 rows dropped; err_clear -> 0; FIFO still drains the original 8 rows.
- Inject col 2 valid one cycle late -> skew_err=1 and that row is not pushed; other rows are unaffected.
- Assert rst_n low mid-tile after 2 rows are pushed -> out_valid=0, fifo_free=8, errors 0; a following clean tile outputs correctly.
- PSUM_ACCUM_EN: tile A all 5 with accum_last=0, then tile B all 7 with accum_last=1 -> no output after A; four rows of 12 after B. Values 0x7FFF+1 wrap to 0x8000.
